// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write-only target: state encoding,
// FIFO word layout and the default device address.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4,
        ST_IGNORE   = 3'd5
    } i2c_state_t;

    localparam int         FIFO_W           = 9;
    localparam int         FLAG_BIT         = 8;
    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h21;
    localparam logic [3:0] BITS_PER_BYTE    = 4'd8;

    // True when the address byte selects this target with a write request.
    function automatic logic addr_write_match(input logic [7:0] addr_byte,
                                              input logic [6:0] dev_addr);
        return (addr_byte[7:1] == dev_addr) && (addr_byte[0] == 1'b0);
    endfunction

endpackage

// File: rtl/i2c_slave_rx_filter.sv
// Input conditioning for one bus line: synchronizer chain, stability
// filter and single-cycle rise/fall pulses on the filtered level.
module i2c_in_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic CLK,
    input  logic nRST,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [3:0]             cnt_r;
    logic                   level_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   sync_out_s;

    assign sync_out_s = sync_r[SYNC_STAGES-1];
    assign level      = level_r;
    assign rise       = rise_r;
    assign fall       = fall_r;

    // Metastability synchronizer; idle bus level is high.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

    // Accept a new level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_r   <= 4'd0;
            level_r <= 1'b1;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            if (sync_out_s == level_r) begin
                cnt_r <= 4'd0;
            end else if (cnt_r == CNT_LAST) begin
                cnt_r   <= 4'd0;
                level_r <= sync_out_s;
                rise_r  <= sync_out_s;
                fall_r  <= ~sync_out_s;
            end else begin
                cnt_r <= cnt_r + 4'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_slave_rx.sv
// I2C/SCCB write-only target: detects START/STOP, matches the device
// address, ACKs each accepted byte and pushes it into a downstream FIFO.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              SCL,
    inout  wire               SDA,
    output logic              FIFO_WE,
    output logic [FIFO_W-1:0] FIFO_Data,
    input  logic              FIFO_Full,
    output logic              BUSY,
    output logic              OVERFLOW
);

    logic scl_lvl_s, scl_rise_s, scl_fall_s;
    logic sda_lvl_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;

    i2c_state_t        state_r,   state_n;
    logic [3:0]        bit_cnt_r, bit_cnt_n;
    logic [7:0]        shift_r,   shift_n;
    logic              first_r,   first_n;
    logic              drive_r,   drive_n;
    logic              we_r,      we_n;
    logic [FIFO_W-1:0] data_r,    data_n;
    logic              busy_r,    busy_n;
    logic              ovf_r,     ovf_n;

    i2c_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .CLK   (CLK),
        .nRST  (nRST),
        .din   (SCL),
        .level (scl_lvl_s),
        .rise  (scl_rise_s),
        .fall  (scl_fall_s)
    );

    i2c_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .CLK   (CLK),
        .nRST  (nRST),
        .din   (SDA),
        .level (sda_lvl_s),
        .rise  (sda_rise_s),
        .fall  (sda_fall_s)
    );

    assign start_s   = sda_fall_s & scl_lvl_s;
    assign stop_s    = sda_rise_s & scl_lvl_s;

    assign SDA       = drive_r ? 1'b0 : 1'bz;
    assign FIFO_WE   = we_r;
    assign FIFO_Data = data_r;
    assign BUSY      = busy_r;
    assign OVERFLOW  = ovf_r;

    // Next-state and output decode; bus conditions override any SCL edge.
    always_comb begin
        state_n   = state_r;
        bit_cnt_n = bit_cnt_r;
        shift_n   = shift_r;
        first_n   = first_r;
        drive_n   = drive_r;
        we_n      = 1'b0;
        data_n    = data_r;
        busy_n    = busy_r;
        ovf_n     = ovf_r;

        if (start_s) begin
            state_n   = ST_ADDR;
            bit_cnt_n = 4'd0;
            drive_n   = 1'b0;
            busy_n    = 1'b1;
            first_n   = 1'b1;
        end else if (stop_s) begin
            state_n   = ST_IDLE;
            bit_cnt_n = 4'd0;
            drive_n   = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    drive_n = 1'b0;
                end
                ST_ADDR: begin
                    if (scl_rise_s && (bit_cnt_r < BITS_PER_BYTE)) begin
                        shift_n   = {shift_r[6:0], sda_lvl_s};
                        bit_cnt_n = bit_cnt_r + 4'd1;
                    end else if (scl_fall_s && (bit_cnt_r == BITS_PER_BYTE)) begin
                        if (addr_write_match(shift_r, DEV_ADDR)) begin
                            state_n = ST_ADDR_ACK;
                            drive_n = 1'b1;
                        end else begin
                            state_n = ST_IGNORE;
                            drive_n = 1'b0;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt_r;
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    if (scl_fall_s) begin
                        drive_n   = 1'b0;
                        state_n   = ST_DATA;
                        bit_cnt_n = 4'd0;
                    end else begin
                        drive_n = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (scl_rise_s && (bit_cnt_r < BITS_PER_BYTE)) begin
                        shift_n   = {shift_r[6:0], sda_lvl_s};
                        bit_cnt_n = bit_cnt_r + 4'd1;
                    end else if (scl_fall_s && (bit_cnt_r == BITS_PER_BYTE)) begin
                        if (!FIFO_Full) begin
                            we_n    = 1'b1;
                            data_n  = {first_r, shift_r};
                            first_n = 1'b0;
                            drive_n = 1'b1;
                            state_n = ST_DATA_ACK;
                        end else begin
                            ovf_n   = 1'b1;
                            drive_n = 1'b0;
                            state_n = ST_IGNORE;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt_r;
                    end
                end
                ST_IGNORE: begin
                    drive_n = 1'b0;
                end
                default: begin
                    state_n = ST_IDLE;
                    drive_n = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; reset releases SDA immediately.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            first_r   <= 1'b0;
            drive_r   <= 1'b0;
            we_r      <= 1'b0;
            data_r    <= 9'h000;
            busy_r    <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            state_r   <= state_n;
            bit_cnt_r <= bit_cnt_n;
            shift_r   <= shift_n;
            first_r   <= first_n;
            drive_r   <= drive_n;
            we_r      <= we_n;
            data_r    <= data_n;
            busy_r    <= busy_n;
            ovf_r     <= ovf_n;
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed testbench for i2c_slave_rx acting as the I2C bus master.
module tb_i2c_slave_rx;
    import i2c_pkg::*;

    localparam int Q = 8;   // CLK cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic       fifo_full = 1'b0;
    logic       fifo_we;
    logic [8:0] fifo_data;
    logic       busy;
    logic       overflow;
    wire        sda_w;

    pullup (sda_w);
    assign sda_w = m_sda_low ? 1'b0 : 1'bz;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int we_cnt = 0;
    int we_cyc = 0;
    int dut_low_cnt = 0;
    int fall_cyc = 0;
    int fall8_cyc = 0;
    logic [8:0] last_data = 9'h000;
    logic sampled;
    logic ack;
    int base;

    i2c_slave_rx dut (
        .CLK       (clk),
        .nRST      (n_rst),
        .SCL       (scl),
        .SDA       (sda_w),
        .FIFO_WE   (fifo_we),
        .FIFO_Data (fifo_data),
        .FIFO_Full (fifo_full),
        .BUSY      (busy),
        .OVERFLOW  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: log FIFO writes and any low level the DUT puts on SDA.
    always @(negedge clk) begin
        if (fifo_we === 1'b1) begin
            we_cnt    = we_cnt + 1;
            we_cyc    = cyc;
            last_data = fifo_data;
        end
        if (!m_sda_low && sda_w === 1'b0) dut_low_cnt = dut_low_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        sampled = sda_w;
        wait_clk(Q);
        scl = 1'b0;
        fall_cyc = cyc;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        fall8_cyc = fall_cyc;
        write_bit(1'b1);
        acked = (sampled === 1'b0);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_sda_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_sda_low = 1'b0;
        wait_clk(2 * Q);
    endtask

    initial begin
        // Reset values
        wait_clk(3);
        check("rst_we", 32'(fifo_we), 32'h0);
        check("rst_data", 32'(fifo_data), 32'h000);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_sda", 32'(sda_w), 32'h1);
        n_rst = 1'b1;
        wait_clk(10);

        // One-CLK SDA glitch while SCL high is filtered out
        m_sda_low = 1'b1;
        wait_clk(1);
        m_sda_low = 1'b0;
        wait_clk(12);
        check("glitch_busy", 32'(busy), 32'h0);

        // Write 0x42, 0x12, 0x80, STOP
        i2c_start();
        check("t1_busy", 32'(busy), 32'h1);
        write_byte(8'h42, ack);
        check("t1_addr_ack", 32'(ack), 32'h1);
        write_byte(8'h12, ack);
        check("t1_d0_ack", 32'(ack), 32'h1);
        check("t1_d0_cnt", 32'(we_cnt), 32'd1);
        check("t1_d0_data", 32'(last_data), 32'h112);
        check("t1_latency", 32'(we_cyc - fall8_cyc), 32'd6);
        write_byte(8'h80, ack);
        check("t1_d1_ack", 32'(ack), 32'h1);
        check("t1_d1_cnt", 32'(we_cnt), 32'd2);
        check("t1_d1_data", 32'(last_data), 32'h080);
        i2c_stop();
        check("t1_busy_stop", 32'(busy), 32'h0);
        check("t1_data_hold", 32'(fifo_data), 32'h080);

        // Address mismatch 0x44 then two bytes
        base = dut_low_cnt;
        i2c_start();
        write_byte(8'h44, ack);
        check("mm_addr_nack", 32'(ack), 32'h0);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack);
        check("mm_state", 32'(dut.state_r), 32'(ST_IGNORE));
        check("mm_busy", 32'(busy), 32'h1);
        i2c_stop();
        check("mm_sda_low", 32'(dut_low_cnt - base), 32'd0);
        check("mm_we_cnt", 32'(we_cnt), 32'd2);
        check("mm_busy_stop", 32'(busy), 32'h0);

        // Read request 0x43
        i2c_start();
        write_byte(8'h43, ack);
        check("rd_nack", 32'(ack), 32'h0);
        i2c_stop();
        check("rd_we_cnt", 32'(we_cnt), 32'd2);

        // FIFO full on the second data byte
        i2c_start();
        write_byte(8'h42, ack);
        check("of_addr_ack", 32'(ack), 32'h1);
        write_byte(8'h33, ack);
        check("of_d0_ack", 32'(ack), 32'h1);
        check("of_d0_data", 32'(last_data), 32'h133);
        fifo_full = 1'b1;
        write_byte(8'h55, ack);
        check("of_d1_nack", 32'(ack), 32'h0);
        check("of_we_cnt", 32'(we_cnt), 32'd3);
        check("of_ovf", 32'(overflow), 32'h1);
        i2c_stop();
        fifo_full = 1'b0;

        // Repeated START after 4 bits of a data byte
        i2c_start();
        write_byte(8'h42, ack);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        i2c_start();
        check("rs_we_cnt_partial", 32'(we_cnt), 32'd3);
        write_byte(8'h42, ack);
        check("rs_addr_ack", 32'(ack), 32'h1);
        write_byte(8'hA5, ack);
        check("rs_d_ack", 32'(ack), 32'h1);
        check("rs_we_cnt", 32'(we_cnt), 32'd4);
        check("rs_data", 32'(last_data), 32'h1A5);
        i2c_stop();
        check("rs_ovf_sticky", 32'(overflow), 32'h1);

        // nRST asserted while the DUT drives the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(1'((8'h42 >> i) & 8'h01));
        m_sda_low = 1'b0;
        wait_clk(1);
        check("rr_ack_driven", 32'(sda_w), 32'h0);
        n_rst = 1'b0;
        #1;
        check("rr_sda", 32'(sda_w), 32'h1);
        check("rr_we", 32'(fifo_we), 32'h0);
        check("rr_data", 32'(fifo_data), 32'h000);
        check("rr_busy", 32'(busy), 32'h0);
        check("rr_ovf", 32'(overflow), 32'h0);
        scl = 1'b1;
        wait_clk(10);
        n_rst = 1'b1;
        wait_clk(10);
        check("rr_busy_after", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
